// File: rtl/mult_acc_stage_3_if.sv
// Stage-2 to stage-3 bundle: MAC operand/control inputs and the neuron-memory write port.
// Inputs are valid-only strobes sampled every posedge with no backpressure; mem_we is a 1-cycle valid pulse.
interface mult_acc_stage_3_if;
    logic        done_3;
    logic [15:0] neuron_val_3;
    logic [7:0]  weight_val_3;
    logic [7:0]  bias_val_3;
    logic        reset_mult_acc_3;
    logic [11:0] out_neuron_addr_3;
    logic        write_neuron_3;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_data;
    logic [12:0] neurons_written;
    logic        layer_done;
    logic [1:0]  state_dbg;

    modport master (
        output done_3, neuron_val_3, weight_val_3, bias_val_3,
               reset_mult_acc_3, out_neuron_addr_3, write_neuron_3,
        input  mem_we, mem_addr, mem_data, neurons_written, layer_done, state_dbg
    );

    modport slave (
        input  done_3, neuron_val_3, weight_val_3, bias_val_3,
               reset_mult_acc_3, out_neuron_addr_3, write_neuron_3,
        output mem_we, mem_addr, mem_data, neurons_written, layer_done, state_dbg
    );
endinterface

// File: rtl/mult_acc_stage_3.sv
// Stage-3 signed MAC per output neuron: bias add, ReLU/clamp to Q8.8, one registered
// neuron-memory write per finalize, and a sticky end-of-layer flag.
module mult_acc_stage_3 #(
    parameter int ACC_W   = 36,
    parameter bit RELU_EN = 1'b1
) (
    input logic               clk,
    input logic               reset,
    mult_acc_stage_3_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

    localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] NEG_MIN = ACC_W'(-32768);

    state_t                   state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     mem_we_q, mem_we_d;
    logic [11:0]              mem_addr_q, mem_addr_d;
    logic [15:0]              mem_data_q, mem_data_d;
    logic [12:0]              nw_q, nw_d;
    logic                     layer_done_q, layer_done_d;

    logic signed [23:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  acc_fin;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [15:0]              result;
    logic                     live;
    logic                     fin;

    // Operands widened to 24 bits so the full Q.15 product is exact.
    assign prod     = $signed({{8{bus.neuron_val_3[15]}}, bus.neuron_val_3}) *
                      $signed({{16{bus.weight_val_3[7]}}, bus.weight_val_3});
    assign prod_ext = {{(ACC_W-24){prod[23]}}, prod};
    assign bias_ext = {{(ACC_W-16){bus.bias_val_3[7]}}, bus.bias_val_3, 8'h00};

    // In IDLE the accumulator is logically empty, giving a bias-only neuron.
    assign acc_fin  = (state_q == ACC) ? acc_q : '0;
    assign sum      = acc_fin + bias_ext;
    assign shifted  = sum >>> 7;

    always_comb begin
        result = shifted[15:0];
        if (RELU_EN && shifted[ACC_W-1]) begin
            result = 16'h0000;
        end else if (shifted > POS_MAX) begin
            result = 16'h7FFF;
        end else if (shifted < NEG_MIN) begin
            result = 16'h8000;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        nw_d         = nw_q;
        layer_done_d = layer_done_q;
        live         = (state_q != DONE);
        fin          = live && bus.write_neuron_3;

        if (fin) begin
            mem_we_d   = 1'b1;
            mem_addr_d = bus.out_neuron_addr_3;
            mem_data_d = result;
            if (nw_q != 13'd4096) begin
                nw_d = nw_q + 13'd1;
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.reset_mult_acc_3) begin
                    acc_d   = prod_ext;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (bus.reset_mult_acc_3) begin
                    acc_d = prod_ext;
                end else if (bus.write_neuron_3) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end else begin
                    acc_d = acc_q + prod_ext;
                end
            end
            default: ;
        endcase

        if (live && bus.done_3) begin
            state_d      = DONE;
            layer_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            nw_q         <= '0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            nw_q         <= nw_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign bus.mem_we          = mem_we_q;
    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_data        = mem_data_q;
    assign bus.neurons_written = nw_q;
    assign bus.layer_done      = layer_done_q;
    assign bus.state_dbg       = state_q;
endmodule

// File: tb/tb_mult_acc_stage_3.sv
// Directed bench for mult_acc_stage_3: ReLU and signed-clamp instances driven in lockstep and
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_mult_acc_stage_3;
    logic clk;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    bit   cmp_en = 0;

    mult_acc_stage_3_if if1 ();
    mult_acc_stage_3_if if0 ();

    mult_acc_stage_3 #(.ACC_W(36), .RELU_EN(1'b1)) dut_relu (.clk(clk), .reset(reset), .bus(if1));
    mult_acc_stage_3 #(.ACC_W(36), .RELU_EN(1'b0)) dut_clamp (.clk(clk), .reset(reset), .bus(if0));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint      m_acc;
    bit          m_active;
    bit          m_done;
    bit          e_we;
    logic [11:0] e_addr;
    logic [15:0] e_d1, e_d0;
    int          e_nw;
    bit          e_ld;

    function automatic logic [15:0] relu_f(input longint r);
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return 16'(r);
    endfunction

    function automatic logic [15:0] clamp_f(input longint r);
        if (r < -32768) return 16'h8000;
        if (r > 32767) return 16'h7FFF;
        return 16'(r);
    endfunction

    always @(posedge clk) begin
        longint p, f, r;
        if (reset) begin
            m_acc = 0; m_active = 0; m_done = 0;
            e_we = 0; e_addr = '0; e_d1 = '0; e_d0 = '0; e_nw = 0; e_ld = 0;
        end else begin
            e_we = 0;
            if (!m_done) begin
                p = longint'($signed(if1.neuron_val_3)) * longint'($signed(if1.weight_val_3));
                if (if1.write_neuron_3) begin
                    f = (m_active ? m_acc : 0) + longint'($signed(if1.bias_val_3)) * 256;
                    r = f >>> 7;
                    e_we = 1; e_addr = if1.out_neuron_addr_3;
                    e_d1 = relu_f(r); e_d0 = clamp_f(r);
                    if (e_nw < 4096) e_nw++;
                end
                if (if1.reset_mult_acc_3) begin
                    m_acc = p; m_active = 1;
                end else if (if1.write_neuron_3) begin
                    m_acc = 0; m_active = 0;
                end else if (m_active) begin
                    m_acc += p;
                end
                if (if1.done_3) begin
                    m_done = 1; e_ld = 1;
                end
            end
        end
    end

    // Every-cycle compare of both instances against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_we_relu",   32'(if1.mem_we),          32'(e_we));
            check("cmp_we_clamp",  32'(if0.mem_we),          32'(e_we));
            check("cmp_addr_relu", 32'(if1.mem_addr),        32'(e_addr));
            check("cmp_addr_clamp",32'(if0.mem_addr),        32'(e_addr));
            check("cmp_data_relu", 32'(if1.mem_data),        32'(e_d1));
            check("cmp_data_clamp",32'(if0.mem_data),        32'(e_d0));
            check("cmp_nw_relu",   32'(if1.neurons_written), 32'(e_nw));
            check("cmp_nw_clamp",  32'(if0.neurons_written), 32'(e_nw));
            check("cmp_ld_relu",   32'(if1.layer_done),      32'(e_ld));
            check("cmp_ld_clamp",  32'(if0.layer_done),      32'(e_ld));
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input bit wr, input bit ra, input logic [15:0] n, input logic [7:0] w,
                         input logic [7:0] b, input logic [11:0] a, input bit dn);
        if1.write_neuron_3 = wr;  if0.write_neuron_3 = wr;
        if1.reset_mult_acc_3 = ra; if0.reset_mult_acc_3 = ra;
        if1.neuron_val_3 = n;     if0.neuron_val_3 = n;
        if1.weight_val_3 = w;     if0.weight_val_3 = w;
        if1.bias_val_3 = b;       if0.bias_val_3 = b;
        if1.out_neuron_addr_3 = a; if0.out_neuron_addr_3 = a;
        if1.done_3 = dn;          if0.done_3 = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 16'h0, 8'h0, 8'h0, 12'h0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        reset = 1'b0;
    endtask

    task automatic check_write(input string name, input logic [11:0] a,
                               input logic [15:0] d1, input logic [15:0] d0);
        check({name, "_we"},    32'(if1.mem_we),   32'd1);
        check({name, "_addr"},  32'(if1.mem_addr), 32'(a));
        check({name, "_relu"},  32'(if1.mem_data), 32'(d1));
        check({name, "_clamp"}, 32'(if0.mem_data), 32'(d0));
        check({name, "_model"}, 32'(e_d1),         32'(d1));
    endtask

    task automatic check_zero(input string name);
        check({name, "_we"},   32'(if1.mem_we),          32'd0);
        check({name, "_addr"}, 32'(if1.mem_addr),        32'd0);
        check({name, "_data"}, 32'(if0.mem_data),        32'd0);
        check({name, "_nw"},   32'(if1.neurons_written), 32'd0);
        check({name, "_ld"},   32'(if0.layer_done),      32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        reset = 1'b1;
        idle();
        idle();
        reset = 1'b0;
        cmp_en = 1;
        check_zero("reset");

        // 1.0 * 0.5, no bias
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h005, 0);
        check_write("t1", 12'h005, 16'h0080, 16'h0080);
        check("t1_nw", 32'(if1.neurons_written), 32'd1);
        idle();
        check("t1_we_low", 32'(if1.mem_we), 32'd0);
        check("t1_data_hold", 32'(if1.mem_data), 32'h0080);

        // same term with +0.5 and -1.0 bias
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h40, 12'h006, 0);
        check_write("t2a", 12'h006, 16'h0100, 16'h0100);
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h80, 12'h007, 0);
        check_write("t2b", 12'h007, 16'h0000, 16'hFF80);

        // negative product
        drive(0, 1, 16'h0100, 8'hC0, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h008, 0);
        check_write("t3", 12'h008, 16'h0000, 16'hFF80);

        // positive saturation over four terms
        drive(0, 1, 16'h7FFF, 8'h7F, 8'h00, 12'h000, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 16'h7FFF, 8'h7F, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h7F, 12'h009, 0);
        check_write("t4", 12'h009, 16'h7FFF, 16'h7FFF);
        check("t4_nw", 32'(if1.neurons_written), 32'd5);

        // negative saturation over four terms
        drive(0, 1, 16'h8000, 8'h7F, 8'h00, 12'h000, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 16'h8000, 8'h7F, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h80, 12'h00D, 0);
        check_write("t4n", 12'h00D, 16'h0000, 16'h8000);

        // write + restart in the same cycle
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 1, 16'h0200, 8'h40, 8'h00, 12'h00A, 0);
        check_write("t5a", 12'h00A, 16'h0080, 16'h0080);
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h00B, 0);
        check_write("t5b", 12'h00B, 16'h0100, 16'h0100);

        // bias-only neuron from IDLE
        drive(1, 0, 16'h0300, 8'h20, 8'h40, 12'h00C, 0);
        check_write("bias_only", 12'h00C, 16'h0080, 16'h0080);

        // reset coinciding with a write suppresses it and drops the partial sum
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        reset = 1'b1;
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h0EE, 0);
        reset = 1'b0;
        check_zero("rst_wr");
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h0EF, 0);
        check_write("rst_partial", 12'h0EF, 16'h0000, 16'h0000);

        // neurons_written saturates at 4096
        for (int i = 0; i < 4100; i++) drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'(i), 0);
        check("nw_sat", 32'(if1.neurons_written), 32'd4096);
        check("nw_sat_clamp", 32'(if0.neurons_written), 32'd4096);

        // done_3 together with a write
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h00, 12'h011, 1);
        check_write("t6", 12'h011, 16'h0080, 16'h0080);
        check("t6_ld", 32'(if1.layer_done), 32'd1);
        drive(0, 1, 16'h0100, 8'h40, 8'h00, 12'h000, 0);
        drive(1, 0, 16'h0000, 8'h00, 8'h40, 12'h012, 0);
        check("t6_no_we", 32'(if1.mem_we), 32'd0);
        check("t6_addr_hold", 32'(if1.mem_addr), 32'h011);
        check("t6_ld_sticky", 32'(if0.layer_done), 32'd1);
        idle();
        do_reset();
        check_zero("t6_reset");
        idle();

        cmp_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
